// File: rtl/ssd1331_spi_rx_if.sv
// SPI pins and decoded outputs of the SSD1331 receiver.
// master: SPI host / observer side; slave: receiver side.
interface ssd1331_spi_rx_if;
  logic        oled_csn;
  logic        oled_clk;
  logic        oled_mosi;
  logic        oled_dc;
  logic        cmd_strobe;
  logic [7:0]  cmd_code;
  logic        pixel_we;
  logic [12:0] pixel_addr;
  logic [15:0] pixel_data;
  logic        display_on;

  modport master (
    output oled_csn, oled_clk, oled_mosi, oled_dc,
    input  cmd_strobe, cmd_code, pixel_we, pixel_addr, pixel_data, display_on
  );

  modport slave (
    input  oled_csn, oled_clk, oled_mosi, oled_dc,
    output cmd_strobe, cmd_code, pixel_we, pixel_addr, pixel_data, display_on
  );
endinterface

// File: rtl/ssd1331_spi_rx.sv
// SSD1331 SPI slave: decodes command opcodes and RGB565 pixel writes into a 96x64 frame.
// Define SSD1331_RX_WINDOW_EN to let 0x15/0x75 arguments set the column/row window.
module ssd1331_spi_rx (
  input  logic              clk,
  input  logic              reset,
  ssd1331_spi_rx_if.slave   bus
);

  typedef enum logic [0:0] {StIdle, StArgs} state_e;

  // Sync order: {csn, sclk, mosi, dc}
  logic [3:0] sync1_q, sync2_q;
  logic       sclk_prev_q;
  logic       sclk_rise;
  logic [2:0] bit_cnt_q;
  logic [6:0] shift_q;
  logic       byte_done_q, byte_dc_q;
  logic [7:0] byte_q;

  state_e      state_q, state_d;
  logic [1:0]  args_q, args_d;
  logic        phase_q, phase_d;
  logic [7:0]  hi_q, hi_d;
  logic [6:0]  col_q, col_d, row_q, row_d;
  logic [6:0]  col_start_q, col_start_d, col_end_q, col_end_d;
  logic [6:0]  row_start_q, row_start_d, row_end_q, row_end_d;
  logic        cmd_strobe_q, cmd_strobe_d, pixel_we_q, pixel_we_d;
  logic        display_on_q, display_on_d;
  logic [7:0]  cmd_code_q, cmd_code_d;
  logic [12:0] pixel_addr_q, pixel_addr_d;
  logic [15:0] pixel_data_q, pixel_data_d;
`ifdef SSD1331_RX_WINDOW_EN
  logic       win_cmd_q, win_cmd_d, win_row_q, win_row_d;
  logic [7:0] arg0_q, arg0_d;
  logic [7:0] win_limit;
  logic [6:0] win_lo, win_hi;
`endif

  function automatic logic is_one_arg(input logic [7:0] op);
    case (op)
      8'h81, 8'h82, 8'h83, 8'h87, 8'h8A, 8'h8B, 8'h8C, 8'hA0, 8'hA1, 8'hA2,
      8'hA8, 8'hAD, 8'hB0, 8'hB1, 8'hB3, 8'hBB, 8'hBE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign sclk_rise = sync2_q[2] & ~sclk_prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= 4'b1000;
      sync2_q     <= 4'b1000;
      sclk_prev_q <= 1'b0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 7'd0;
      byte_done_q <= 1'b0;
      byte_dc_q   <= 1'b0;
      byte_q      <= 8'd0;
    end else begin
      sync1_q     <= {bus.oled_csn, bus.oled_clk, bus.oled_mosi, bus.oled_dc};
      sync2_q     <= sync1_q;
      sclk_prev_q <= sync2_q[2];
      byte_done_q <= 1'b0;
      if (sync2_q[3]) begin
        bit_cnt_q <= 3'd0;
      end else if (sclk_rise) begin
        bit_cnt_q <= bit_cnt_q + 3'd1;
        shift_q   <= {shift_q[5:0], sync2_q[1]};
        if (bit_cnt_q == 3'd7) begin
          byte_done_q <= 1'b1;
          byte_q      <= {shift_q, sync2_q[1]};
          byte_dc_q   <= sync2_q[0];
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    args_d       = args_q;
    phase_d      = phase_q;
    hi_d         = hi_q;
    col_d        = col_q;
    row_d        = row_q;
    col_start_d  = col_start_q;
    col_end_d    = col_end_q;
    row_start_d  = row_start_q;
    row_end_d    = row_end_q;
    cmd_strobe_d = 1'b0;
    pixel_we_d   = 1'b0;
    cmd_code_d   = cmd_code_q;
    display_on_d = display_on_q;
    pixel_addr_d = pixel_addr_q;
    pixel_data_d = pixel_data_q;
`ifdef SSD1331_RX_WINDOW_EN
    win_cmd_d = win_cmd_q;
    win_row_d = win_row_q;
    arg0_d    = arg0_q;
    win_limit = win_row_q ? 8'd63 : 8'd95;
    win_lo    = (arg0_q > win_limit) ? win_limit[6:0] : arg0_q[6:0];
    win_hi    = (byte_q > win_limit) ? win_limit[6:0] : byte_q[6:0];
    if (win_hi < win_lo) win_hi = win_lo;
`endif
    if (byte_done_q) begin
      if (!byte_dc_q) begin
        phase_d = 1'b0;
        unique case (state_q)
          StIdle: begin
            cmd_strobe_d = 1'b1;
            cmd_code_d   = byte_q;
            if (byte_q == 8'hAF) display_on_d = 1'b1;
            if (byte_q == 8'hAE) display_on_d = 1'b0;
            if (byte_q == 8'h15 || byte_q == 8'h75) begin
              state_d = StArgs;
              args_d  = 2'd2;
            end else if (is_one_arg(byte_q)) begin
              state_d = StArgs;
              args_d  = 2'd1;
            end
`ifdef SSD1331_RX_WINDOW_EN
            win_cmd_d = (byte_q == 8'h15 || byte_q == 8'h75);
            win_row_d = (byte_q == 8'h75);
`endif
          end
          StArgs: begin
`ifdef SSD1331_RX_WINDOW_EN
            if (win_cmd_q && args_q == 2'd2) begin
              arg0_d = byte_q;
            end else if (win_cmd_q) begin
              if (win_row_q) begin
                row_start_d = win_lo;
                row_end_d   = win_hi;
                row_d       = win_lo;
              end else begin
                col_start_d = win_lo;
                col_end_d   = win_hi;
                col_d       = win_lo;
              end
            end
`endif
            args_d = args_q - 2'd1;
            if (args_q == 2'd1) state_d = StIdle;
          end
          default: state_d = StIdle;
        endcase
      end else begin
        // Pixel data aborts any command still waiting for arguments.
        state_d = StIdle;
        args_d  = 2'd0;
        if (!phase_q) begin
          hi_d    = byte_q;
          phase_d = 1'b1;
        end else begin
          phase_d      = 1'b0;
          pixel_we_d   = 1'b1;
          pixel_data_d = {hi_q, byte_q};
          pixel_addr_d = 13'(row_q) * 13'd96 + 13'(col_q);
          if (col_q == col_end_q) begin
            col_d = col_start_q;
            row_d = (row_q == row_end_q) ? row_start_q : row_q + 7'd1;
          end else begin
            col_d = col_q + 7'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      args_q       <= 2'd0;
      phase_q      <= 1'b0;
      hi_q         <= 8'd0;
      col_q        <= 7'd0;
      row_q        <= 7'd0;
      col_start_q  <= 7'd0;
      col_end_q    <= 7'd95;
      row_start_q  <= 7'd0;
      row_end_q    <= 7'd63;
      cmd_strobe_q <= 1'b0;
      pixel_we_q   <= 1'b0;
      cmd_code_q   <= 8'd0;
      display_on_q <= 1'b0;
      pixel_addr_q <= 13'd0;
      pixel_data_q <= 16'd0;
`ifdef SSD1331_RX_WINDOW_EN
      win_cmd_q    <= 1'b0;
      win_row_q    <= 1'b0;
      arg0_q       <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      args_q       <= args_d;
      phase_q      <= phase_d;
      hi_q         <= hi_d;
      col_q        <= col_d;
      row_q        <= row_d;
      col_start_q  <= col_start_d;
      col_end_q    <= col_end_d;
      row_start_q  <= row_start_d;
      row_end_q    <= row_end_d;
      cmd_strobe_q <= cmd_strobe_d;
      pixel_we_q   <= pixel_we_d;
      cmd_code_q   <= cmd_code_d;
      display_on_q <= display_on_d;
      pixel_addr_q <= pixel_addr_d;
      pixel_data_q <= pixel_data_d;
`ifdef SSD1331_RX_WINDOW_EN
      win_cmd_q    <= win_cmd_d;
      win_row_q    <= win_row_d;
      arg0_q       <= arg0_d;
`endif
    end
  end

  assign bus.cmd_strobe = cmd_strobe_q;
  assign bus.cmd_code   = cmd_code_q;
  assign bus.pixel_we   = pixel_we_q;
  assign bus.pixel_addr = pixel_addr_q;
  assign bus.pixel_data = pixel_data_q;
  assign bus.display_on = display_on_q;

endmodule

// File: tb/tb_ssd1331_spi_rx.sv
// Directed bench for ssd1331_spi_rx: commands, pixels, CSN abort, reset and window handling.
module tb_ssd1331_spi_rx;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ssd1331_spi_rx_if bus ();
  ssd1331_spi_rx dut (.clk(clk), .reset(reset), .bus(bus));

  int passed = 0;
  int total  = 0;
  int strobe_cnt = 0;
  logic [12:0] addr_log[$];
  logic [15:0] data_log[$];

  always @(negedge clk) begin
    if (bus.cmd_strobe) strobe_cnt++;
    if (bus.pixel_we) begin
      addr_log.push_back(bus.pixel_addr);
      data_log.push_back(bus.pixel_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic send_byte(input logic dc, input logic [7:0] b);
    bus.oled_csn = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      bus.oled_clk  = 1'b0;
      bus.oled_mosi = b[i];
      bus.oled_dc   = dc;
      #40;
      bus.oled_clk = 1'b1;
      #40;
    end
  endtask

  task automatic end_frame();
    bus.oled_csn = 1'b1;
    bus.oled_clk = 1'b0;
    #200;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #27;
    reset = 1'b0;
    #20;
  endtask

  int s0, n0, bad;

  initial begin
    bus.oled_csn = 1'b1; bus.oled_clk = 1'b0; bus.oled_mosi = 1'b0; bus.oled_dc = 1'b0;
    reset = 1'b1;
    #37;
    check("rst_strobe", 32'(bus.cmd_strobe), 0);
    check("rst_we", 32'(bus.pixel_we), 0);
    check("rst_code", 32'(bus.cmd_code), 0);
    check("rst_disp", 32'(bus.display_on), 0);
    check("rst_addr_data", {3'd0, bus.pixel_addr, bus.pixel_data}, 0);
    reset = 1'b0;
    #20;

    // Display on/off
    s0 = strobe_cnt;
    send_byte(1'b0, 8'hAF); end_frame();
    check("af_strobes", 32'(strobe_cnt - s0), 1);
    check("af_code", 32'(bus.cmd_code), 32'hAF);
    check("af_disp", 32'(bus.display_on), 1);
    send_byte(1'b0, 8'hAE); end_frame();
    check("ae_code", 32'(bus.cmd_code), 32'hAE);
    check("ae_disp", 32'(bus.display_on), 0);

    // First pixel after reset
    n0 = addr_log.size();
    send_byte(1'b1, 8'hF8); send_byte(1'b1, 8'h1F); end_frame();
    check("px0_count", 32'(addr_log.size() - n0), 1);
    check("px0_data", 32'(data_log[n0]), 32'hF81F);
    check("px0_addr", 32'(addr_log[n0]), 0);

    // Partial byte discarded by CSN
    s0 = strobe_cnt;
    bus.oled_csn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.oled_clk = 1'b0; bus.oled_mosi = 1'b1; bus.oled_dc = 1'b0; #40;
      bus.oled_clk = 1'b1; #40;
    end
    end_frame();
    send_byte(1'b0, 8'hAE); end_frame();
    check("csn_strobes", 32'(strobe_cnt - s0), 1);
    check("csn_code", 32'(bus.cmd_code), 32'hAE);

    // 0xAF as argument of 0xA0 is not a command
    s0 = strobe_cnt;
    send_byte(1'b0, 8'hA0); send_byte(1'b0, 8'hAF); end_frame();
    check("arg_strobes", 32'(strobe_cnt - s0), 1);
    check("arg_code", 32'(bus.cmd_code), 32'hA0);
    check("arg_disp", 32'(bus.display_on), 0);

    // Pixel bytes abort a pending argument; cursor now at col 1
    n0 = addr_log.size();
    send_byte(1'b0, 8'h81); send_byte(1'b1, 8'h11); send_byte(1'b1, 8'h22); end_frame();
    check("abort_count", 32'(addr_log.size() - n0), 1);
    check("abort_data", 32'(data_log[n0]), 32'h1122);
    check("abort_addr", 32'(addr_log[n0]), 1);

    // Command byte resets pixel phase
    n0 = addr_log.size();
    send_byte(1'b1, 8'hAA); send_byte(1'b0, 8'hE3);
    send_byte(1'b1, 8'h56); send_byte(1'b1, 8'h78); end_frame();
    check("phase_count", 32'(addr_log.size() - n0), 1);
    check("phase_data", 32'(data_log[n0]), 32'h5678);
    check("phase_addr", 32'(addr_log[n0]), 2);

    // Reset after a high pixel byte
    send_byte(1'b1, 8'hAB); end_frame();
    pulse_reset();
    check("rst2_code", 32'(bus.cmd_code), 0);
    n0 = addr_log.size();
    send_byte(1'b1, 8'h12); send_byte(1'b1, 8'h34); end_frame();
    check("rst2_count", 32'(addr_log.size() - n0), 1);
    check("rst2_data", 32'(data_log[n0]), 32'h1234);
    check("rst2_addr", 32'(addr_log[n0]), 0);

    // Window commands
    pulse_reset();
    s0 = strobe_cnt;
    send_byte(1'b0, 8'h15); send_byte(1'b0, 8'h02); send_byte(1'b0, 8'h03);
    send_byte(1'b0, 8'h75); send_byte(1'b0, 8'h05); send_byte(1'b0, 8'h06);
    end_frame();
    check("win_strobes", 32'(strobe_cnt - s0), 2);
    check("win_code", 32'(bus.cmd_code), 32'h75);
    n0 = addr_log.size();
`ifdef SSD1331_RX_WINDOW_EN
    for (int i = 0; i < 5; i++) begin
      send_byte(1'b1, 8'(i)); send_byte(1'b1, 8'hC0);
    end
    end_frame();
    check("win_count", 32'(addr_log.size() - n0), 5);
    check("win_a0", 32'(addr_log[n0]), 482);
    check("win_a1", 32'(addr_log[n0 + 1]), 483);
    check("win_a2", 32'(addr_log[n0 + 2]), 578);
    check("win_a3", 32'(addr_log[n0 + 3]), 579);
    check("win_a4", 32'(addr_log[n0 + 4]), 482);
    check("win_d4", 32'(data_log[n0 + 4]), 32'h04C0);
`else
    for (int i = 0; i < 97; i++) begin
      send_byte(1'b1, 8'(i)); send_byte(1'b1, 8'(255 - i));
    end
    end_frame();
    check("seq_count", 32'(addr_log.size() - n0), 97);
    bad = 0;
    for (int i = 0; i < 97; i++) begin
      if (n0 + i < addr_log.size()) begin
        if (addr_log[n0 + i] !== 13'(i)) bad++;
        if (data_log[n0 + i] !== {8'(i), 8'(255 - i)}) bad++;
      end
    end
    check("seq_mismatches", 32'(bad), 0);
    check("seq_a95", 32'(addr_log[n0 + 95]), 95);
    check("seq_a96", 32'(addr_log[n0 + 96]), 96);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ssd1331_spi_rx.md
SSD1331_SPI_RX -- requirements
Module: ssd1331_spi_rx

Interface
REQ-001 clk  input  1  system clock; all state on its rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 oled_csn  input  1  SPI chip select, active low, asynchronous to clk.
REQ-004 oled_clk  input  1  SPI clock, asynchronous; MOSI sampled on its rising edge.
REQ-005 oled_mosi  input  1  SPI data, MSB first.
REQ-006 oled_dc  input  1  0 = command/argument byte, 1 = pixel data byte.
REQ-007 cmd_strobe  output  1  one-cycle pulse per completed command opcode (not arguments).
REQ-008 cmd_code  output  8  last opcode; valid while cmd_strobe high, held afterwards.
REQ-009 pixel_we  output  1  one-cycle pixel write pulse.
REQ-010 pixel_addr  output  13  row*96+col of the written pixel, range 0..6143.
REQ-011 pixel_data  output  16  RGB565 {first byte, second byte}.
REQ-012 display_on  output  1  1 after opcode 0xAF, 0 after opcode 0xAE.

Function
REQ-013 All four SPI inputs SHALL pass through 2-flop synchronizers; an oled_clk rising edge is detected when the synced value goes from 0 to 1; clk SHALL be at least 4x the SPI clock.
REQ-014 A 3-bit bit counter SHALL shift oled_mosi in MSB first on each detected edge while synced oled_csn is 0; a byte completes on the 8th edge, and oled_dc SHALL be latched at that edge.
REQ-015 Synced oled_csn high SHALL clear the bit counter; a partial byte is discarded with no output effect; the decoder state and pixel phase are kept.
REQ-016 Decoder states: IDLE, ARGS(n remaining, 1..2).
REQ-017 IDLE, dc=0 byte: pulse cmd_strobe and load cmd_code; opcodes 0x15 and 0x75 go to ARGS(2); 0x81,0x82,0x83,0x87,0x8A,0x8B,0x8C,0xA0,0xA1,0xA2,0xA8,0xAD,0xB0,0xB1,0xB3,0xBB,0xBE go to ARGS(1); all other opcodes stay in IDLE.
REQ-018 ARGS, dc=0 byte: the byte is an argument (no cmd_strobe); decrement n and return to IDLE at 0.
REQ-019 A dc=1 byte in ARGS SHALL abort the command (state to IDLE, partial arguments dropped) and SHALL be treated as a pixel byte.
REQ-020 Any dc=0 byte SHALL reset the pixel phase to "high byte next".
REQ-021 dc=1 byte: in phase high, store the byte; in phase low, pulse pixel_we with pixel_data={stored,byte} and pixel_addr=row*96+col, then advance the cursor.
REQ-022 Cursor advance: col==col_end -> col=col_start and row advances; otherwise col+1. Row advance: row==row_end -> row=row_start; otherwise row+1.
REQ-023 pixel_we and cmd_strobe SHALL be registered, asserted the clk cycle after the byte-complete cycle, at most 4 clk after the raw 8th oled_clk rise.
REQ-024 Back-to-back bytes with no CSN gap SHALL be decoded without loss.

Reset
REQ-025 reset SHALL clear all outputs to 0, the bit counter to 0, the state to IDLE and the phase to high, and set col_start/col=0, col_end=95, row_start/row=0, row_end=63; reset mid-byte or mid-pixel discards the partial data.

Configuration
REQ-026 Macro SSD1331_RX_WINDOW_EN: when defined, argument 1 of 0x15 (or 0x75) SHALL set col_start (row_start) and argument 2 SHALL set col_end (row_end).
REQ-027 With SSD1331_RX_WINDOW_EN, values SHALL be clamped to 95 for columns and 63 for rows; if end<start then end=start; the cursor SHALL be loaded to start when the 2nd argument is applied.
REQ-028 Without SSD1331_RX_WINDOW_EN, 0x15/0x75 arguments SHALL be consumed but ignored; the window is fixed at 0..95 x 0..63.

Verification
REQ-029 dc=0 byte 0xAF -> cmd_strobe once, cmd_code=0xAF, display_on=1; then 0xAE -> display_on=0.
REQ-030 dc=1 bytes 0xF8,0x1F after reset -> exactly one pixel_we with pixel_data=0xF81F, pixel_addr=0.
REQ-031 (WINDOW_EN) 0x15,0x02,0x03,0x75,0x05,0x06, then 5 pixels -> pixel_addr 482,483,578,579,482; cmd_strobe pulses only twice.
REQ-032 CSN deasserted after 5 bits, then full dc=0 byte 0xAE -> only 0xAE decoded; no spurious strobe.
REQ-033 (no WINDOW_EN) same window commands, then 97 pixels -> pixel_addr 0..96 sequential.
REQ-034 reset asserted after a high pixel byte, then bytes 0x12,0x34 -> one pixel_we with pixel_data=0x1234, pixel_addr=0.
